// File: rtl/falafel_req_frontend.sv
//------------------------------------------------------------------------------
// Module  : falafel_req_frontend (+ falafel_req_fifo)
// Brief   : Host command demux into alloc/free request FIFOs, and response FIFO
//           returning core results to the host, with sticky protocol errors.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module falafel_req_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic              empty,
    output logic              full,
    output logic [DATA_W-1:0] head
);
    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_ptr_w  = c_addr_w + 1;
    localparam logic [c_ptr_w-1:0] c_full_count = c_ptr_w'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_last_ptr   = c_ptr_w'(DEPTH - 1);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_count;
    logic [c_ptr_w-1:0] w_wr_ptr_nxt;
    logic [c_ptr_w-1:0] w_rd_ptr_nxt;

    // Pointers carry one spare bit but wrap explicitly at DEPTH-1.
    assign w_wr_ptr_nxt = (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_w'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_w'(1);

    assign empty = (r_count == '0);
    assign full  = (r_count == c_full_count);
    assign head  = r_mem[r_rd_ptr[c_addr_w-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                r_mem[r_wr_ptr[c_addr_w-1:0]] <= din;
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            if (push && !pop) begin
                r_count <= r_count + c_ptr_w'(1);
            end else if (pop && !push) begin
                r_count <= r_count - c_ptr_w'(1);
            end
        end
    end
endmodule

module falafel_req_frontend #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_val_i,
    output logic              cmd_rdy_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    output logic              rsp_val_o,
    input  logic              rsp_rdy_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              alloc_fifo_empty_o,
    input  logic              alloc_fifo_read_i,
    output logic [DATA_W-1:0] alloc_fifo_dout_o,
    output logic              free_fifo_empty_o,
    input  logic              free_fifo_read_i,
    output logic [DATA_W-1:0] free_fifo_dout_o,
    output logic              resp_fifo_full_o,
    input  logic              resp_fifo_write_i,
    input  logic [DATA_W-1:0] resp_fifo_din_i,
    output logic              err_illegal_op_o,
    output logic              err_overflow_o,
    output logic              err_underflow_o
);
    localparam logic [1:0] c_op_alloc = 2'b00;
    localparam logic [1:0] c_op_free  = 2'b01;

    logic w_alloc_full;
    logic w_free_full;
    logic w_resp_empty;
    logic w_resp_full;
    logic w_cmd_fire;
    logic w_alloc_push;
    logic w_free_push;
    logic w_illegal;
    logic w_alloc_pop;
    logic w_free_pop;
    logic w_rsp_pop;
    logic w_resp_push;
    logic w_underflow;
    logic w_overflow;
    logic r_err_illegal;
    logic r_err_overflow;
    logic r_err_underflow;

    assign cmd_rdy_o  = !rst_i && !w_alloc_full && !w_free_full;
    assign w_cmd_fire = cmd_val_i && cmd_rdy_o;

    assign w_alloc_push = w_cmd_fire && (cmd_op_i == c_op_alloc);
    assign w_free_push  = w_cmd_fire && (cmd_op_i == c_op_free);
    assign w_illegal    = w_cmd_fire && cmd_op_i[1];

    assign w_alloc_pop = alloc_fifo_read_i && !alloc_fifo_empty_o;
    assign w_free_pop  = free_fifo_read_i && !free_fifo_empty_o;
    assign w_underflow = (alloc_fifo_read_i && alloc_fifo_empty_o)
                       || (free_fifo_read_i && free_fifo_empty_o);

    // A full response FIFO still takes a write when the host drains it in the same cycle.
    assign w_rsp_pop   = !w_resp_empty && rsp_rdy_i;
    assign w_resp_push = resp_fifo_write_i && (!w_resp_full || w_rsp_pop);
    assign w_overflow  = resp_fifo_write_i && w_resp_full && !w_rsp_pop;

    assign rsp_val_o        = !w_resp_empty;
    assign resp_fifo_full_o = w_resp_full;
    assign err_illegal_op_o = r_err_illegal;
    assign err_overflow_o   = r_err_overflow;
    assign err_underflow_o  = r_err_underflow;

    falafel_req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_alloc_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (w_alloc_push),
        .pop   (w_alloc_pop),
        .din   (cmd_data_i),
        .empty (alloc_fifo_empty_o),
        .full  (w_alloc_full),
        .head  (alloc_fifo_dout_o)
    );

    falafel_req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_free_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (w_free_push),
        .pop   (w_free_pop),
        .din   (cmd_data_i),
        .empty (free_fifo_empty_o),
        .full  (w_free_full),
        .head  (free_fifo_dout_o)
    );

    falafel_req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_resp_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (w_resp_push),
        .pop   (w_rsp_pop),
        .din   (resp_fifo_din_i),
        .empty (w_resp_empty),
        .full  (w_resp_full),
        .head  (rsp_data_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err_illegal   <= 1'b0;
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
        end else begin
            if (w_illegal) begin
                r_err_illegal <= 1'b1;
            end
            if (w_overflow) begin
                r_err_overflow <= 1'b1;
            end
            if (w_underflow) begin
                r_err_underflow <= 1'b1;
            end
        end
    end
endmodule

`default_nettype wire

// File: doc/falafel_req_frontend.md
Name: falafel_req_frontend

Overview:
- Host-side front end of the allocator. Accepts a single valid/ready command stream carrying ALLOC (size) or FREE (pointer) requests.
- Demultiplexes commands into two internal request FIFOs, which the allocator core drains through empty/read/dout interfaces.
- Buffers the core's allocation results in an internal response FIFO and returns them to the host over a valid/ready stream.
- Sits directly upstream and downstream of the allocator core; owns all request/response buffering and protocol-error flags.

Parameters:
- DATA_W, 32, width of size/pointer/response words.
- DEPTH, 4, entries per FIFO (alloc, free, resp); power of two, >= 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- cmd_val_i  in  1  host command valid.
- cmd_rdy_o  out  1  front end ready for a command.
- cmd_op_i  in  2  opcode: 2'b00 ALLOC, 2'b01 FREE, 2'b1x illegal.
- cmd_data_i  in  DATA_W  ALLOC size or FREE pointer.
- rsp_val_o  out  1  host response valid.
- rsp_rdy_i  in  1  host ready for the response.
- rsp_data_o  out  DATA_W  allocated pointer, NULL or error code (passed through unmodified).
- alloc_fifo_empty_o  out  1  alloc FIFO empty.
- alloc_fifo_read_i  in  1  core pops the alloc FIFO.
- alloc_fifo_dout_o  out  DATA_W  alloc FIFO head (first-word fall-through).
- free_fifo_empty_o  out  1  free FIFO empty.
- free_fifo_read_i  in  1  core pops the free FIFO.
- free_fifo_dout_o  out  DATA_W  free FIFO head (first-word fall-through).
- resp_fifo_full_o  out  1  resp FIFO full.
- resp_fifo_write_i  in  1  core pushes a response.
- resp_fifo_din_i  in  DATA_W  response word from the core.
- err_illegal_op_o  out  1  sticky: an illegal opcode was accepted.
- err_overflow_o  out  1  sticky: core wrote while resp FIFO was full.
- err_underflow_o  out  1  sticky: core read an empty alloc or free FIFO.

Behaviour:
- Reset (rst_i high at a clock edge):
  - All FIFO read/write pointers and counts go to 0.
  - alloc_fifo_empty_o = free_fifo_empty_o = 1; resp_fifo_full_o = 0.
  - rsp_val_o = 0, cmd_rdy_o = 0 during the reset cycle, all err_* = 0.
  - dout/rsp_data_o are don't-care while empty; they drive 0 after reset.
  - Reset mid-operation discards all buffered entries; no partial state survives.
- Each FIFO is a circular buffer with wr_ptr, rd_ptr and count, each $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
  - empty = (count == 0); full = (count == DEPTH).
  - Head output is the combinational read of mem[rd_ptr].
  - A write at edge N makes the entry visible at the head (empty deasserted) in cycle N+1.
  - A pop at edge N presents the next entry in cycle N+1.
- cmd_rdy_o = !rst_i && !alloc_full && !free_full. It is registered-state-only and does not depend on cmd_val_i or cmd_op_i.
- Command accepted when cmd_val_i && cmd_rdy_o:
  - ALLOC: push cmd_data_i into the alloc FIFO.
  - FREE: push cmd_data_i into the free FIFO.
  - Illegal opcode: drop the data, set err_illegal_op_o. No FIFO changes.
- Core side:
  - alloc_fifo_read_i / free_fifo_read_i pop when the FIFO is non-empty.
  - A pop on an empty FIFO is ignored and sets err_underflow_o.
  - resp_fifo_write_i pushes when not full, or when full and the host pops in the same cycle.
  - Otherwise a full-FIFO write is dropped and sets err_overflow_o.
- Response side: rsp_val_o = !resp_empty; rsp_data_o = resp head. Pop on rsp_val_o && rsp_rdy_i. rsp_val_o must stay asserted with stable data until accepted.
- Simultaneous push and pop:
  - Non-empty, non-full FIFO: both occur, count unchanged.
  - Empty FIFO: the pop is ignored (this is not an underflow when the pop comes from the host side) and the push occurs.
  - Full resp FIFO with host pop: both occur.
- Ordering: FIFOs are strictly in-order. There is no ordering between the alloc and free queues; the core arbitrates them.
- Sticky err_* flags are cleared only by reset.

Test Plan:
- Reset, then host sends ALLOC 0x10 -> alloc_fifo_empty_o falls the next cycle with dout 0x10; core pulses read -> empty rises the next cycle; free FIFO untouched.
- DEPTH=4: push 4 ALLOCs (0x8, 0x10, 0x18, 0x20) with no core reads -> cmd_rdy_o low after the 4th; core pops one -> cmd_rdy_o high the next cycle; 5th command 0x28 emerges after 0x20 (wrap-around check).
- Core writes 0x1000, 0x2000 with rsp_rdy_i low -> rsp_val_o=1, data 0x1000 held stable; raise rsp_rdy_i -> 0x1000 then 0x2000 delivered, then rsp_val_o=0.
- Fill resp FIFO (4 entries), core writes 0xDEAD with rsp_rdy_i=0 -> write dropped, err_overflow_o=1; repeat with rsp_rdy_i=1 -> write accepted, count stays 4, no new error.
- cmd_op_i=2'b11, data 0x55 -> accepted, both FIFOs stay empty, err_illegal_op_o=1; core pulses free_fifo_read_i while empty -> err_underflow_o=1.
- Three mixed commands buffered, assert rst_i for one cycle -> all FIFOs empty, rsp_val_o=0, err_* cleared, cmd_rdy_o high the following cycle.
